// File: rtl/multicycle_ctrl.sv
// Multicycle sequencer for the MIPS-subset datapath: fetch/decode/exec/mem/wb
// timing, write-strobe gating and bounded memory-wait timeout.
module multicycle_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             imemReady,
    input  logic             dmemReady,
    input  logic [1:0]       pcSrcCtrl,
    input  logic [1:0]       regDInCtrl,
    input  logic             regWe,
    input  logic             dmWe,
    output logic             irWe,
    output logic             imemReq,
    output logic             dmemReq,
    output logic             dmemWe,
    output logic             regFileWe,
    output logic             pcWe,
    output logic [1:0]       pcSel,
    output logic [2:0]       state,
    output logic             err,
    output logic [CNT_W-1:0] instrCount
);

    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WW-1:0] LIM = WW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_ERR    = 3'd6,
        S_BAD    = 3'd7
    } state_t;

    state_t           r_state;
    logic [WW-1:0]    r_wait;
    logic [1:0]       r_pcSel;
    logic [1:0]       r_regDIn;
    logic             r_regWe;
    logic             r_dmWe;
    logic [CNT_W-1:0] r_cnt;

    logic w_irWe;
    logic w_imemReq;
    logic w_dmemReq;
    logic w_dmemWe;
    logic w_regFileWe;
    logic w_pcWe;
    logic w_toMem;

    // Loads and stores both take the MEM detour; the latched fields decide.
    assign w_toMem = r_dmWe || (r_regDIn == 2'b01);

    always_comb begin
        w_irWe      = 1'b0;
        w_imemReq   = 1'b0;
        w_dmemReq   = 1'b0;
        w_dmemWe    = 1'b0;
        w_regFileWe = 1'b0;
        w_pcWe      = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_imemReq = 1'b1;
                w_irWe    = imemReady;
            end
            S_EXEC: begin
                w_pcWe = !w_toMem && !r_regWe;
            end
            S_MEM: begin
                w_dmemReq = 1'b1;
                w_dmemWe  = r_dmWe && dmemReady;
                w_pcWe    = r_dmWe && dmemReady;
            end
            S_WB: begin
                w_regFileWe = 1'b1;
                w_pcWe      = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_wait   <= '0;
            r_pcSel  <= '0;
            r_regDIn <= '0;
            r_regWe  <= 1'b0;
            r_dmWe   <= 1'b0;
            r_cnt    <= '0;
        end else begin
            if (w_pcWe)
                r_cnt <= r_cnt + CNT_W'(1);
            case (r_state)
                S_IDLE: begin
                    r_wait <= '0;
                    if (run)
                        r_state <= S_FETCH;
                end
                S_FETCH: begin
                    if (imemReady)
                        r_state <= S_DECODE;
                    else if (r_wait == LIM)
                        r_state <= S_ERR;
                    else
                        r_wait <= r_wait + WW'(1);
                end
                S_DECODE: begin
                    r_pcSel  <= pcSrcCtrl;
                    r_regDIn <= regDInCtrl;
                    r_regWe  <= regWe;
                    r_dmWe   <= dmWe;
                    r_state  <= S_EXEC;
                end
                S_EXEC: begin
                    r_wait <= '0;
                    if (r_dmWe && r_regWe)
                        r_state <= S_ERR;
                    else if (w_toMem)
                        r_state <= S_MEM;
                    else if (r_regWe)
                        r_state <= S_WB;
                    else
                        r_state <= run ? S_FETCH : S_IDLE;
                end
                S_MEM: begin
                    if (dmemReady) begin
                        r_wait <= '0;
                        if (r_dmWe)
                            r_state <= run ? S_FETCH : S_IDLE;
                        else
                            r_state <= S_WB;
                    end else if (r_wait == LIM) begin
                        r_state <= S_ERR;
                    end else begin
                        r_wait <= r_wait + WW'(1);
                    end
                end
                S_WB: begin
                    r_wait  <= '0;
                    r_state <= run ? S_FETCH : S_IDLE;
                end
                S_ERR: r_state <= S_ERR;
                default: r_state <= S_ERR;
            endcase
        end
    end

    assign irWe       = w_irWe;
    assign imemReq    = w_imemReq;
    assign dmemReq    = w_dmemReq;
    assign dmemWe     = w_dmemWe;
    assign regFileWe  = w_regFileWe;
    assign pcWe       = w_pcWe;
    assign pcSel      = r_pcSel;
    assign state      = r_state;
    assign err        = (r_state == S_ERR);
    assign instrCount = r_cnt;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: instruction classes, memory waits,
// timeout boundary, illegal decode and reset behaviour.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        imemReady;
    logic        dmemReady;
    logic [1:0]  pcSrcCtrl;
    logic [1:0]  regDInCtrl;
    logic        regWe;
    logic        dmWe;
    logic        irWe;
    logic        imemReq;
    logic        dmemReq;
    logic        dmemWe;
    logic        regFileWe;
    logic        pcWe;
    logic [1:0]  pcSel;
    logic [2:0]  state;
    logic        err;
    logic [31:0] instrCount;

    int checks = 0;
    int errors = 0;

    multicycle_ctrl #(.TIMEOUT(16), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .run(run),
        .imemReady(imemReady), .dmemReady(dmemReady),
        .pcSrcCtrl(pcSrcCtrl), .regDInCtrl(regDInCtrl),
        .regWe(regWe), .dmWe(dmWe),
        .irWe(irWe), .imemReq(imemReq), .dmemReq(dmemReq),
        .dmemWe(dmemWe), .regFileWe(regFileWe), .pcWe(pcWe),
        .pcSel(pcSel), .state(state), .err(err),
        .instrCount(instrCount)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic dec(input logic [1:0] pc, input logic [1:0] rd,
                       input logic rw, input logic dw);
        pcSrcCtrl  = pc;
        regDInCtrl = rd;
        regWe      = rw;
        dmWe       = dw;
    endtask

    initial begin
        reset = 1'b1; run = 1'b0;
        imemReady = 1'b0; dmemReady = 1'b0;
        dec(2'b00, 2'b00, 1'b0, 1'b0);
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("rst_state", state, 0);
        chk("rst_err", err, 0);
        chk("rst_cnt", instrCount, 0);
        chk("rst_pcWe", pcWe, 0);
        chk("rst_imemReq", imemReq, 0);

        // ALU instructions: 1,2,3,5 repeating
        run = 1'b1; imemReady = 1'b1; dmemReady = 1'b1;
        dec(2'b00, 2'b00, 1'b1, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("alu_fetch", state, 1);
            chk("alu_irWe", irWe, 1);
            chk("alu_imemReq", imemReq, 1);
            tick();
            chk("alu_decode", state, 2);
            chk("alu_dec_irWe", irWe, 0);
            tick();
            chk("alu_exec", state, 3);
            chk("alu_exec_pcWe", pcWe, 0);
            tick();
            chk("alu_wb", state, 5);
            chk("alu_wb_rfWe", regFileWe, 1);
            chk("alu_wb_pcWe", pcWe, 1);
            tick();
        end
        chk("alu_cnt", instrCount, 3);
        chk("alu_back", state, 1);

        // Jumps: retire in EXEC, 3 cycles each
        dec(2'b10, 2'b00, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            chk("jmp_fetch", state, 1);
            tick();
            chk("jmp_decode", state, 2);
            tick();
            chk("jmp_exec", state, 3);
            chk("jmp_pcWe", pcWe, 1);
            chk("jmp_pcSel", pcSel, 2'b10);
            chk("jmp_rfWe", regFileWe, 0);
            tick();
        end
        chk("jmp_cnt", instrCount, 5);
        chk("jmp_back", state, 1);

        // Store: dmemWe and pcWe together in MEM's ready cycle
        dec(2'b00, 2'b00, 1'b0, 1'b1);
        tick();
        tick();
        chk("st_exec", state, 3);
        chk("st_exec_pcWe", pcWe, 0);
        chk("st_pcSel", pcSel, 2'b00);
        tick();
        chk("st_mem", state, 4);
        chk("st_dmemReq", dmemReq, 1);
        chk("st_dmemWe", dmemWe, 1);
        chk("st_pcWe", pcWe, 1);
        chk("st_rfWe", regFileWe, 0);
        tick();
        chk("st_back", state, 1);
        chk("st_cnt", instrCount, 6);

        // Load with two dmem wait cycles: 7 cycles to retire
        dec(2'b00, 2'b01, 1'b1, 1'b0);
        tick();
        tick();
        dmemReady = 1'b0;
        tick();
        for (int i = 0; i < 2; i++) begin
            chk("ld_mem_wait", state, 4);
            chk("ld_wait_req", dmemReq, 1);
            chk("ld_wait_we", dmemWe, 0);
            chk("ld_wait_pcWe", pcWe, 0);
            tick();
        end
        dmemReady = 1'b1;
        #1;
        chk("ld_mem_rdy", state, 4);
        chk("ld_rdy_we", dmemWe, 0);
        chk("ld_rdy_pcWe", pcWe, 0);
        tick();
        chk("ld_wb", state, 5);
        chk("ld_wb_rfWe", regFileWe, 1);
        chk("ld_wb_pcWe", pcWe, 1);
        tick();
        chk("ld_cnt", instrCount, 7);
        chk("ld_back", state, 1);

        // run dropped during WB: instruction retires, then IDLE
        dec(2'b00, 2'b00, 1'b1, 1'b0);
        tick(); tick(); tick();
        run = 1'b0;
        #1;
        chk("stop_wb", state, 5);
        chk("stop_wb_pcWe", pcWe, 1);
        tick();
        chk("stop_idle", state, 0);
        chk("stop_cnt", instrCount, 8);
        tick();
        chk("stop_stay", state, 0);

        // Ready on the 16th FETCH cycle wins over the timeout
        run = 1'b1; imemReady = 1'b0;
        tick();
        run = 1'b0;
        for (int i = 0; i < 15; i++) begin
            chk("to_edge_fetch", state, 1);
            tick();
        end
        imemReady = 1'b1;
        #1;
        chk("to_edge_irWe", irWe, 1);
        dec(2'b00, 2'b00, 1'b1, 1'b1);
        tick();
        chk("to_edge_decode", state, 2);
        chk("to_edge_err", err, 0);
        tick();
        chk("ill_exec", state, 3);
        chk("ill_pcWe", pcWe, 0);
        tick();
        chk("ill_err_state", state, 6);
        chk("ill_err", err, 1);
        run = 1'b1; dmemReady = 1'b1;
        #1;
        chk("ill_imemReq", imemReq, 0);
        chk("ill_irWe", irWe, 0);
        tick();
        chk("err_sticky", state, 6);
        chk("err_cnt", instrCount, 8);

        reset = 1'b1;
        tick();
        reset = 1'b0; run = 1'b0;
        #1;
        chk("rst2_state", state, 0);
        chk("rst2_err", err, 0);
        chk("rst2_cnt", instrCount, 0);

        // 16 not-ready FETCH cycles -> ERR
        run = 1'b1; imemReady = 1'b0;
        tick();
        for (int i = 0; i < 16; i++) begin
            chk("to_fetch", state, 1);
            chk("to_req", imemReq, 1);
            tick();
        end
        chk("to_err_state", state, 6);
        chk("to_err", err, 1);
        chk("to_err_req", imemReq, 0);

        // Reset while waiting in MEM
        reset = 1'b1;
        tick();
        reset = 1'b0;
        run = 1'b1; imemReady = 1'b1; dmemReady = 1'b0;
        dec(2'b01, 2'b00, 1'b1, 1'b0);
        tick(); tick(); tick(); tick();
        chk("mr_wb", state, 5);
        tick();
        chk("mr_cnt1", instrCount, 1);
        dec(2'b11, 2'b01, 1'b1, 1'b0);
        tick(); tick(); tick();
        chk("mr_mem", state, 4);
        chk("mr_pcSel", pcSel, 2'b11);
        tick();
        chk("mr_mem_wait", state, 4);
        reset = 1'b1;
        tick();
        reset = 1'b0; run = 1'b0;
        #1;
        chk("mr_state", state, 0);
        chk("mr_cnt", instrCount, 0);
        chk("mr_dmemReq", dmemReq, 0);
        chk("mr_dmemWe", dmemWe, 0);
        chk("mr_pcWe", pcWe, 0);
        chk("mr_rfWe", regFileWe, 0);
        chk("mr_irWe", irWe, 0);
        chk("mr_pcSel0", pcSel, 0);
        chk("mr_err", err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
